pic8259_lite: RTL and testbench

- Simplified single-master 8259-style interrupt controller.
- Sits directly downstream of the timer: its irq[0] input takes the timer's irq0 square wave. irq[7:1] take the other peripheral requests.
- Presents one interrupt request plus an 8-bit vector to the CPU core.
- Programmed through the same toggle-handshake I/O port interface as the other chipset peripherals, at ports BASE_PORT and BASE_PORT+1.

---
 rtl/pic8259_lite.sv | 192 +++++++++++++++++++
 tb/tb_pic8259_lite.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic8259_lite.sv
// Single-master 8259-style interrupt controller: edge-triggered requests, fixed priority
// (line 0 highest), ICW1/ICW2/ICW4 init, OCW1/OCW2/OCW3, toggle-handshake I/O at BASE_PORT.
module pic8259_lite #(
  parameter logic [11:0] BASE_PORT   = 12'h020,
  parameter logic [7:0]  RESET_VBASE = 8'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] port,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic        cpu_iordin,
  output logic        cpu_iordout,
  input  logic        cpu_iowrin,
  output logic        cpu_iowrout,
  input  logic [7:0]  irq,
  input  logic        inta,
  output logic        intr,
  output logic [7:0]  vector
);

  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_WAIT_ICW2 = 2'd1,
    ST_WAIT_ICW4 = 2'd2
  } state_t;

  // Index of the lowest set bit, or 8 when no bit is set.
  function automatic logic [3:0] f_lowest(input logic [7:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] f_onehot(input logic [3:0] idx);
    return idx[3] ? 8'h00 : (8'h01 << idx[2:0]);
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_iord;
  logic        r_iowr;
  logic        r_cs_cmd;
  logic        r_cs_data;
  logic [15:0] r_dout;
  logic [7:0]  r_s1;
  logic [7:0]  r_s2;
  logic [7:0]  r_d;
  logic [7:0]  r_irr;
  logic [7:0]  r_isr;
  logic [7:0]  r_imr;
  logic [4:0]  r_vbase;
  logic        r_rsel;
  logic        r_icw4;
  logic        r_intr;
  logic [7:0]  r_vector;

  logic        w_wr;
  logic [7:0]  w_byte;
  logic        w_wr_cmd;
  logic        w_wr_data;
  logic        w_ready;
  logic        w_icw1;
  logic        w_ocw1;
  logic        w_ocw2;
  logic        w_ocw3;
  logic [7:0]  w_eoi_mask;
  logic [7:0]  w_req;
  logic [3:0]  w_p;
  logic [3:0]  w_s;
  logic        w_pending;
  logic [7:0]  w_ack_mask;
  logic [7:0]  w_rise;
  logic [7:0]  w_irr_nxt;
  logic [7:0]  w_isr_nxt;
  logic [7:0]  w_rd_sel;

  assign w_wr      = r_iowr ^ cpu_iowrin;
  assign w_byte    = port[0] ? din[15:8] : din[7:0];
  assign w_wr_cmd  = w_wr & r_cs_cmd;
  assign w_wr_data = w_wr & r_cs_data;
  assign w_ready   = (r_state == ST_READY);
  assign w_icw1    = w_wr_cmd & w_byte[4];
  assign w_ocw1    = w_wr_data & w_ready;
  assign w_ocw2    = w_wr_cmd & ~w_byte[4] & ~w_byte[3] & w_ready;
  assign w_ocw3    = w_wr_cmd & ~w_byte[4] &  w_byte[3] & w_ready;

  assign w_req      = r_irr & ~r_imr;
  assign w_p        = f_lowest(w_req);
  assign w_s        = f_lowest(r_isr);
  assign w_pending  = (w_req != 8'h00) && (w_p < w_s);
  assign w_ack_mask = (inta && w_pending) ? f_onehot(w_p) : 8'h00;
  assign w_rise     = r_s2 & ~r_d;

  always_comb begin
    w_eoi_mask = 8'h00;
    if (w_ocw2) begin
      if (w_byte == 8'h20) begin
        w_eoi_mask = f_onehot(w_s);
      end else if (w_byte[7:3] == 5'b01100) begin
        w_eoi_mask = 8'h01 << w_byte[2:0];
      end
    end
  end

  // A rise on a line being acknowledged in the same cycle keeps its request;
  // EOI clears before the ack sets, and ICW1 overrides both.
  assign w_irr_nxt = (r_irr & ~w_ack_mask) | w_rise;
  assign w_isr_nxt = w_icw1 ? 8'h00 : ((r_isr & ~w_eoi_mask) | w_ack_mask);
  assign w_rd_sel  = r_rsel ? r_isr : r_irr;

  always_comb begin
    w_state_nxt = r_state;
    if (w_icw1) begin
      w_state_nxt = ST_WAIT_ICW2;
    end else if (w_wr_data) begin
      case (r_state)
        ST_WAIT_ICW2: w_state_nxt = r_icw4 ? ST_WAIT_ICW4 : ST_READY;
        ST_WAIT_ICW4: w_state_nxt = ST_READY;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_READY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iord    <= 1'b0;
      r_iowr    <= 1'b0;
      r_cs_cmd  <= 1'b0;
      r_cs_data <= 1'b0;
      r_dout    <= 16'hFFFF;
      r_s1      <= 8'h00;
      r_s2      <= 8'h00;
      r_d       <= 8'h00;
      r_irr     <= 8'h00;
      r_isr     <= 8'h00;
      r_imr     <= 8'hFF;
      r_vbase   <= RESET_VBASE[7:3];
      r_rsel    <= 1'b0;
      r_icw4    <= 1'b0;
      r_intr    <= 1'b0;
      r_vector  <= 8'h00;
    end else begin
      r_iord    <= cpu_iordin;
      r_iowr    <= cpu_iowrin;
      r_cs_cmd  <= (port == BASE_PORT);
      r_cs_data <= (port == BASE_PORT + 12'd1);
      r_s1      <= irq;
      r_s2      <= r_s1;
      r_d       <= r_s2;
      r_irr     <= w_irr_nxt;
      r_isr     <= w_isr_nxt;
      if (w_icw1) begin
        r_imr  <= 8'h00;
        r_rsel <= 1'b0;
        r_icw4 <= w_byte[0];
      end else begin
        if (w_ocw1) r_imr <= w_byte;
        if (w_wr_data && (r_state == ST_WAIT_ICW2)) r_vbase <= w_byte[7:3];
        if (w_ocw3 && w_byte[1]) r_rsel <= w_byte[0];
      end
      r_intr   <= w_pending;
      r_vector <= {r_vbase, w_p[2:0]};
      if (r_cs_cmd) begin
        r_dout <= {w_rd_sel, w_rd_sel};
      end else if (r_cs_data) begin
        r_dout <= {r_imr, r_imr};
      end else begin
        r_dout <= 16'hFFFF;
      end
    end
  end

  assign dout        = r_dout;
  assign cpu_iordout = r_iord;
  assign cpu_iowrout = r_iowr;
  assign intr        = r_intr;
  // During inta the vector reflects the live decision so a spurious ack reads level 7.
  assign vector      = inta ? {r_vbase, (w_pending ? w_p[2:0] : 3'd7)} : r_vector;

endmodule

// File: tb/tb_pic8259_lite.sv
// Randomized scoreboard bench for pic8259_lite against a register-level behavioural model.
module tb_pic8259_lite;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] port;
  logic [15:0] din;
  logic [15:0] dout;
  logic        cpu_iordin;
  logic        cpu_iordout;
  logic        cpu_iowrin;
  logic        cpu_iowrout;
  logic [7:0]  irq;
  logic        inta;
  logic        intr;
  logic [7:0]  vector;
  logic        chk_stb;

  int errors = 0;
  int checks = 0;

  logic [15:0] rd_q[$];
  logic [7:0]  ack_q[$];
  logic [8:0]  st_q[$];
  logic        seen_rd;

  logic [7:0]  m_irr, m_isr, m_imr;
  logic [4:0]  m_vbase;
  logic        m_rsel, m_icw4;
  int          m_state;

  pic8259_lite #(.BASE_PORT(12'h020), .RESET_VBASE(8'h08)) dut (
    .clk(clk), .reset(reset), .port(port), .din(din), .dout(dout),
    .cpu_iordin(cpu_iordin), .cpu_iordout(cpu_iordout),
    .cpu_iowrin(cpu_iowrin), .cpu_iowrout(cpu_iowrout),
    .irq(irq), .inta(inta), .intr(intr), .vector(vector)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic no_entry(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry", nm);
  endtask

  // ---------------- reference model ----------------
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic int m_p();
    return lowest(m_irr & ~m_imr);
  endfunction

  function automatic bit m_pend();
    return (m_p() < 8) && (m_p() < lowest(m_isr));
  endfunction

  function automatic logic [7:0] m_vec();
    return {m_vbase, 3'(m_p())};
  endfunction

  task automatic m_reset();
    m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_vbase = 5'h01;
    m_rsel = 1'b0; m_icw4 = 1'b0; m_state = 0;
  endtask

  task automatic m_write(input logic [11:0] p, input logic [7:0] b);
    int s;
    if (p == 12'h020) begin
      if (b[4]) begin
        m_isr = 8'h00; m_imr = 8'h00; m_rsel = 1'b0; m_icw4 = b[0]; m_state = 1;
      end else if (m_state == 0) begin
        if (!b[3]) begin
          if (b == 8'h20) begin
            s = lowest(m_isr);
            if (s < 8) m_isr[s] = 1'b0;
          end else if (b[7:3] == 5'b01100) begin
            m_isr[b[2:0]] = 1'b0;
          end
        end else if (b[1]) begin
          m_rsel = b[0];
        end
      end
    end else if (p == 12'h021) begin
      if (m_state == 1) begin
        m_vbase = b[7:3];
        m_state = m_icw4 ? 2 : 0;
      end else if (m_state == 2) begin
        m_state = 0;
      end else begin
        m_imr = b;
      end
    end
  endtask

  function automatic logic [15:0] m_read(input logic [11:0] p);
    if (p == 12'h020) return m_rsel ? {m_isr, m_isr} : {m_irr, m_irr};
    if (p == 12'h021) return {m_imr, m_imr};
    return 16'hFFFF;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      seen_rd <= 1'b0;
    end else begin
      if (cpu_iordout !== seen_rd) begin
        seen_rd <= cpu_iordout;
        if (rd_q.size() == 0) no_entry("read");
        else chk("read_dout", dout, rd_q.pop_front());
      end
      if (inta) begin
        if (ack_q.size() == 0) no_entry("inta");
        else chk("inta_vector", {8'h00, vector}, {8'h00, ack_q.pop_front()});
      end
      if (chk_stb) begin
        if (st_q.size() == 0) no_entry("state");
        else chk("intr_vector", {7'b0, intr, (intr ? vector : 8'h00)}, {7'b0, st_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [11:0] p, input logic [7:0] b);
    port = p;
    din = p[0] ? {b, 8'h5A} : {8'hA5, b};
    cyc(1);
    cpu_iowrin = ~cpu_iowrin;
    cyc(1);
    m_write(p, b);
    cyc(1);
  endtask

  task automatic io_read(input logic [11:0] p);
    port = p;
    cyc(2);
    rd_q.push_back(m_read(p));
    cpu_iordin = ~cpu_iordin;
    cyc(2);
  endtask

  task automatic do_inta();
    int p;
    if (m_pend()) begin
      p = m_p();
      ack_q.push_back(m_vec());
      m_irr[p] = 1'b0;
      m_isr[p] = 1'b1;
    end else begin
      ack_q.push_back({m_vbase, 3'd7});
    end
    inta = 1'b1;
    cyc(1);
    inta = 1'b0;
    cyc(2);
  endtask

  task automatic set_irq(input logic [7:0] v);
    m_irr = m_irr | (v & ~irq);
    irq = v;
    cyc(5);
  endtask

  task automatic check_state();
    st_q.push_back({m_pend(), (m_pend() ? m_vec() : 8'h00)});
    chk_stb = 1'b1;
    cyc(1);
    chk_stb = 1'b0;
  endtask

  task automatic reinit(input logic [7:0] vb, input logic icw4);
    io_write(12'h020, 8'h10 | {7'b0, icw4});
    io_write(12'h021, vb);
    if (icw4) io_write(12'h021, 8'($urandom));
  endtask

  function automatic logic [11:0] pick_port(input int k);
    case (k)
      0: return 12'h020;
      1: return 12'h021;
      2: return 12'h022;
      3: return 12'h01F;
      4: return 12'h120;
      default: return 12'h821;
    endcase
  endfunction

  initial begin
    reset = 1'b1; port = 12'h000; din = 16'h0000; cpu_iordin = 1'b0; cpu_iowrin = 1'b0;
    irq = 8'h00; inta = 1'b0; chk_stb = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_intr", 16'(intr), 16'h0000);
    chk("reset_dout", dout, 16'hFFFF);
    chk("reset_acks", {14'b0, cpu_iordout, cpu_iowrout}, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(2);
    io_read(12'h020);
    io_read(12'h021);

    reinit(8'h08, 1'b1);
    io_write(12'h021, 8'hFE);
    io_read(12'h021);

    // Latency: drive after edge k, intr must rise at edge k+4.
    irq = 8'h01;
    m_irr[0] = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("latency_early", 16'(intr), 16'h0000);
    @(negedge clk);
    chk("latency_intr", 16'(intr), 16'h0001);
    @(posedge clk); #1;
    check_state();
    do_inta();
    io_write(12'h020, 8'h20);
    set_irq(8'h00);

    io_write(12'h021, 8'h00);
    set_irq(8'h0A);
    check_state();
    do_inta();
    check_state();
    io_write(12'h020, 8'h0B);
    io_read(12'h020);
    io_write(12'h020, 8'h20);
    check_state();
    do_inta();
    set_irq(8'h00);
    set_irq(8'h02);
    check_state();
    set_irq(8'h22);
    check_state();
    do_inta();
    check_state();
    io_write(12'h020, 8'h0A);
    io_read(12'h020);
    io_read(12'h022);
    io_write(12'h021, 8'hFF);
    do_inta();
    io_write(12'h020, 8'h63);
    io_write(12'h020, 8'h0B);
    io_read(12'h020);
    check_state();

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 11))
        0, 1, 2: set_irq(8'($urandom));
        3, 4:    do_inta();
        5:       io_write(12'h021, 8'($urandom & $urandom));
        6:       io_write(12'h020, 8'h20);
        7:       io_write(12'h020, 8'h60 | 8'($urandom_range(0, 7)));
        8:       io_write(12'h020, 8'h0A | 8'($urandom_range(0, 1)));
        9:       io_read(pick_port($urandom_range(0, 5)));
        10:      io_write(12'h020, 8'($urandom) & 8'hEF);
        default: begin
          if ($urandom_range(0, 3) == 0) reinit(8'($urandom), 1'($urandom));
          else io_read(pick_port($urandom_range(0, 5)));
        end
      endcase
      check_state();
    end

    // Reset while an interrupt is in service and another is requested.
    reinit(8'h50, 1'b1);
    set_irq(8'h00);
    set_irq(8'h10);
    do_inta();
    set_irq(8'h14);
    check_state();
    reset = 1'b1; cpu_iordin = 1'b0; cpu_iowrin = 1'b0; irq = 8'h00;
    #1;
    chk("async_reset_intr", 16'(intr), 16'h0000);
    m_reset();
    cyc(2);
    reset = 1'b0;
    cyc(2);
    io_read(12'h021);
    io_write(12'h021, 8'hFB);
    set_irq(8'h04);
    check_state();
    do_inta();
    io_write(12'h020, 8'h0B);
    io_read(12'h020);

    cyc(4);
    chk("rd_q_drained", 16'(rd_q.size()), 16'h0000);
    chk("ack_q_drained", 16'(ack_q.size()), 16'h0000);
    chk("st_q_drained", 16'(st_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
